// File: rtl/bus_rr_arbiter_bp.sv
// Shared-bus arbiter: drains DRVRS source FIFOs and routes each packet by its 8-bit dest ID.
// Optional broadcast of dest 0xFF is enabled by defining BUS_BCAST_EN.
module bus_rr_arbiter_bp #(
  parameter int unsigned PCKG_SZ  = 16,
  parameter int unsigned DRVRS    = 8,
  parameter int unsigned ARB_MODE = 0,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DRVRS-1:0]                pndng,
  input  logic [DRVRS-1:0][PCKG_SZ-1:0]   D_pop,
  output logic [DRVRS-1:0]                pop,
  input  logic [DRVRS-1:0]                full,
  output logic [DRVRS-1:0]                push,
  output logic [DRVRS-1:0][PCKG_SZ-1:0]   D_push,
  output logic                            err_drop,
  output logic                            busy
);

  localparam int unsigned IdxW = (DRVRS > 1) ? $clog2(DRVRS) : 1;
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] NumDrv = 8'(DRVRS);
  localparam logic [DRVRS-1:0] Lsb = {{(DRVRS-1){1'b0}}, 1'b1};
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DRVRS - 1);
`ifdef BUS_BCAST_EN
  localparam bit BcastEn = 1'b1;
`else
  localparam bit BcastEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StCheck, StXfer} state_e;

  state_e             state_q;
  logic [IdxW-1:0]    ptr_q;
  logic [IdxW-1:0]    src_q;
  logic [PCKG_SZ-1:0] pkt_q;
  logic [DRVRS-1:0]   mask_q;
  logic [CntW-1:0]    cnt_q;
  logic [DRVRS-1:0]   pop_q;
  logic [DRVRS-1:0]   push_q;
  logic               err_drop_q;

  logic [IdxW-1:0]    grant;
  logic [PCKG_SZ-1:0] win_pkt;
  logic [7:0]         win_dest;
  logic [DRVRS-1:0]   win_mask;
  logic               blocked;

  // Arbitration: fixed priority picks the lowest index; round-robin the first index at or
  // above ptr (with wrap). Iterating downward lets the last assignment be the winner.
  always_comb begin
    int idx;
    grant = '0;
    idx   = 0;
    if (ARB_MODE == 1) begin
      for (int i = int'(DRVRS) - 1; i >= 0; i--) begin
        if (pndng[i]) grant = IdxW'(i);
      end
    end else begin
      for (int i = int'(DRVRS) - 1; i >= 0; i--) begin
        idx = (int'(ptr_q) + i) % int'(DRVRS);
        if (pndng[idx]) grant = IdxW'(idx);
      end
    end
  end

  assign win_pkt  = D_pop[grant];
  assign win_dest = win_pkt[PCKG_SZ-1 -: 8];

  always_comb begin
    win_mask = '0;
    if (win_dest < NumDrv) begin
      win_mask = Lsb << win_dest;
    end else if (BcastEn && (win_dest == 8'hFF)) begin
      win_mask = ~(Lsb << grant);
    end
  end

  assign blocked = |(mask_q & full);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      src_q      <= '0;
      pkt_q      <= '0;
      mask_q     <= '0;
      cnt_q      <= '0;
      pop_q      <= '0;
      push_q     <= '0;
      err_drop_q <= 1'b0;
    end else begin
      pop_q      <= '0;
      push_q     <= '0;
      err_drop_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|pndng) begin
            state_q <= StCheck;
            src_q   <= grant;
            pkt_q   <= win_pkt;
            mask_q  <= win_mask;
            cnt_q   <= '0;
          end
        end
        StCheck: begin
          // Still blocked once the counter reached TIMEOUT means the packet is dropped.
          if (!blocked || (cnt_q == TimeoutCnt)) begin
            state_q    <= StXfer;
            pop_q      <= Lsb << src_q;
            push_q     <= blocked ? '0 : mask_q;
            err_drop_q <= blocked || (mask_q == '0);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StXfer: begin
          state_q <= StIdle;
          ptr_q   <= (src_q == LastIdx) ? '0 : src_q + 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pop      = pop_q;
  assign push     = push_q;
  assign err_drop = err_drop_q;
  assign busy     = (state_q != StIdle);
  assign D_push   = {DRVRS{pkt_q}};

endmodule

// File: tb/tb_bus_rr_arbiter_bp.sv
// Directed bench for bus_rr_arbiter_bp: a round-robin and a fixed-priority instance share stimulus.
module tb_bus_rr_arbiter_bp;
  localparam int PCKG_SZ = 16;
  localparam int DRVRS   = 8;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic reset;
  logic [DRVRS-1:0] pndng, full, pop, push, pop_fp, push_fp;
  logic [DRVRS-1:0][PCKG_SZ-1:0] D_pop, D_push, D_push_fp;
  logic err_drop, busy, err_drop_fp, busy_fp;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_rr_arbiter_bp #(.PCKG_SZ(PCKG_SZ), .DRVRS(DRVRS), .ARB_MODE(0), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop), .full(full),
    .push(push), .D_push(D_push), .err_drop(err_drop), .busy(busy)
  );

  bus_rr_arbiter_bp #(.PCKG_SZ(PCKG_SZ), .DRVRS(DRVRS), .ARB_MODE(1), .TIMEOUT(TIMEOUT)) dut_fp (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop_fp), .full(full),
    .push(push_fp), .D_push(D_push_fp), .err_drop(err_drop_fp), .busy(busy_fp)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #12;
    checks++;
    if (pop !== 8'h00 || push !== 8'h00 || err_drop !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got pop=%h push=%h err=%b busy=%b want all 0",
               pop, push, err_drop, busy);
    end
    checks++;
    if (D_push !== '0) begin
      errors++;
      $display("FAIL reset_dpush: got %h want 0", D_push);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_rr_fairness;
    logic [7:0] exp;
    for (int i = 0; i < DRVRS; i++) D_pop[i] = {8'(i), 8'(192 + i)};
    full  = '0;
    pndng = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      step;
      step;
      exp = 8'(1 << (k % 8));
      checks++;
      if (pop !== exp) begin
        errors++;
        $display("FAIL rr_grant_%0d: got pop=%h want %h", k, pop, exp);
      end
      checks++;
      if (push !== exp) begin
        errors++;
        $display("FAIL rr_push_%0d: got push=%h want %h", k, push, exp);
      end
      checks++;
      if (pop_fp !== 8'h01) begin
        errors++;
        $display("FAIL fp_grant_%0d: got pop=%h want 01", k, pop_fp);
      end
      if (k == 8) pndng = '0;
      step;
    end
    step;
  endtask

  task automatic test_unicast;
    D_pop[2] = 16'h05AB;
    pndng    = 8'h04;
    step;
    checks++;
    if (busy !== 1'b1 || pop !== 8'h00) begin
      errors++;
      $display("FAIL unicast_check_state: got busy=%b pop=%h want 1/00", busy, pop);
    end
    checks++;
    if (D_push !== {8{16'h05AB}}) begin
      errors++;
      $display("FAIL unicast_dpush_early: got %h want lanes 05ab", D_push);
    end
    step;
    checks++;
    if (pop !== 8'h04 || push !== 8'h20 || err_drop !== 1'b0) begin
      errors++;
      $display("FAIL unicast_xfer: got pop=%h push=%h err=%b want 04/20/0", pop, push, err_drop);
    end
    checks++;
    if (D_push !== {8{16'h05AB}}) begin
      errors++;
      $display("FAIL unicast_dpush: got %h want lanes 05ab", D_push);
    end
    pndng = '0;
    step;
    checks++;
    if (pop !== 8'h00 || push !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL unicast_single_pulse: got pop=%h push=%h busy=%b want 00/00/0",
               pop, push, busy);
    end
  endtask

  task automatic test_timeout;
    D_pop[1] = 16'h035A;
    full     = 8'h08;
    pndng    = 8'h02;
    step;
    for (int c = 0; c < TIMEOUT; c++) begin
      step;
      checks++;
      if (pop !== 8'h00 || busy !== 1'b1) begin
        errors++;
        $display("FAIL timeout_stall_%0d: got pop=%h busy=%b want 00/1", c, pop, busy);
      end
    end
    step;
    checks++;
    if (pop !== 8'h02 || push !== 8'h00 || err_drop !== 1'b1) begin
      errors++;
      $display("FAIL timeout_drop: got pop=%h push=%h err=%b want 02/00/1", pop, push, err_drop);
    end
    pndng = '0;
    step;
    checks++;
    if (err_drop !== 1'b0 || pop !== 8'h00) begin
      errors++;
      $display("FAIL timeout_pulse_width: got err=%b pop=%h want 0/00", err_drop, pop);
    end
    full = '0;
  endtask

  task automatic test_release;
    D_pop[1] = 16'h035A;
    full     = 8'h08;
    pndng    = 8'h02;
    step;
    step;
    step;
    checks++;
    if (pop !== 8'h00) begin
      errors++;
      $display("FAIL release_stalled: got pop=%h want 00", pop);
    end
    full = '0;
    step;
    checks++;
    if (pop !== 8'h02 || push !== 8'h08 || err_drop !== 1'b0) begin
      errors++;
      $display("FAIL release_deliver: got pop=%h push=%h err=%b want 02/08/0", pop, push, err_drop);
    end
    pndng = '0;
    step;
  endtask

  task automatic test_invalid_dest;
    D_pop[4] = 16'h1077;
    pndng    = 8'h10;
    step;
    step;
    checks++;
    if (pop !== 8'h10 || push !== 8'h00 || err_drop !== 1'b1) begin
      errors++;
      $display("FAIL invalid_dest: got pop=%h push=%h err=%b want 10/00/1", pop, push, err_drop);
    end
    pndng = '0;
    step;
    checks++;
    if (err_drop !== 1'b0) begin
      errors++;
      $display("FAIL invalid_dest_pulse: got err=%b want 0", err_drop);
    end
  endtask

  task automatic test_broadcast;
    logic [7:0] exp_push;
    logic       exp_err;
`ifdef BUS_BCAST_EN
    exp_push = 8'hFD;
    exp_err  = 1'b0;
`else
    exp_push = 8'h00;
    exp_err  = 1'b1;
`endif
    D_pop[1] = 16'hFF42;
    pndng    = 8'h02;
    step;
    step;
    checks++;
    if (pop !== 8'h02 || push !== exp_push || err_drop !== exp_err) begin
      errors++;
      $display("FAIL broadcast: got pop=%h push=%h err=%b want 02/%h/%b",
               pop, push, err_drop, exp_push, exp_err);
    end
    checks++;
    if (D_push !== {8{16'hFF42}}) begin
      errors++;
      $display("FAIL broadcast_dpush: got %h want lanes ff42", D_push);
    end
    pndng = '0;
    step;
  endtask

  task automatic test_async_reset;
    D_pop[3] = 16'h0512;
    full     = 8'h20;
    pndng    = 8'h08;
    step;
    step;
    checks++;
    if (busy !== 1'b1 || pop !== 8'h00) begin
      errors++;
      $display("FAIL areset_pre: got busy=%b pop=%h want 1/00", busy, pop);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || pop !== 8'h00 || push !== 8'h00 || err_drop !== 1'b0 || D_push !== '0)
    begin
      errors++;
      $display("FAIL areset_immediate: got busy=%b pop=%h push=%h err=%b dpush=%h want zeros",
               busy, pop, push, err_drop, D_push);
    end
    step;
    checks++;
    if (pop !== 8'h00) begin
      errors++;
      $display("FAIL areset_hold: got pop=%h want 00", pop);
    end
    step;
    reset = 1'b0;
    full  = '0;
    step;
    step;
    checks++;
    if (pop !== 8'h08 || push !== 8'h20 || D_push !== {8{16'h0512}}) begin
      errors++;
      $display("FAIL areset_resume: got pop=%h push=%h dpush=%h want 08/20/lanes 0512",
               pop, push, D_push);
    end
    pndng = '0;
    step;
  endtask

  initial begin
    reset = 1'b1;
    pndng = '0;
    full  = '0;
    D_pop = '0;
    test_reset;
    test_rr_fairness;
    test_unicast;
    test_timeout;
    test_release;
    test_invalid_dest;
    test_broadcast;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_rr_arbiter_bp.md
# bus_rr_arbiter_bp

Second-generation shared-bus generator/arbiter for the multi-driver packet bus verification environment. Drains DRVRS source FIFOs, routes each packet by the destination ID in its MSBs to one or all destination FIFOs, and adds three things the first generation lacks:
- selectable arbitration (round-robin or fixed priority);
- destination backpressure with a bounded stall timeout;
- a drop/error report.

It sits between the per-driver FIFOs and the bus interface used by the driver/monitor agents.

## Interface
Parameters:
- PCKG_SZ, 16: packet width in bits; must be ≥ 16.
- DRVRS, 8: number of drivers/ports; 2..254.
- ARB_MODE, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
- TIMEOUT, 64: maximum stall cycles in CHECK before the packet is dropped; ≥ 1.

Ports (clock and reset first):
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- pndng  in  DRVRS  source FIFO i is non-empty; head word is valid on D_pop[i] (first-word-fall-through).
- D_pop  in  DRVRS×PCKG_SZ  head word of each source FIFO.
- pop  out  DRVRS  one-cycle dequeue strobe to the source FIFO.
- full  in  DRVRS  destination FIFO i cannot accept a word.
- push  out  DRVRS  one-cycle enqueue strobe to the destination FIFO.
- D_push  out  DRVRS×PCKG_SZ  shared bus word, identical on every lane.
- err_drop  out  1  one-cycle pulse when a packet is discarded.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- Packet field: dest ID = pkt[PCKG_SZ-1 -: 8]. Payload is opaque and is forwarded unmodified.
- FSM states:
  - IDLE → CHECK when pndng ≠ 0. On that transition, latch src (the arbitration winner) and pkt = D_pop[src], and build the target mask.
  - CHECK → XFER when (mask & full) == 0, or when the stall counter reaches TIMEOUT.
  - XFER → IDLE unconditionally.
- Target mask:
  - dest < DRVRS: one-hot(dest). A dest equal to src is legal and delivered back to src.
  - dest ≥ DRVRS and not broadcast: mask = 0. The packet is an invalid drop.
- Outputs in XFER:
  - pop[src] = 1.
  - push = mask, forced to 0 if the timeout fired.
  - D_push lanes = pkt.
  - err_drop = 1 if mask == 0 or the timeout fired.
- A dropped packet is still popped.
- Round-robin:
  - Search starts at ptr; the first set pndng index wins, searching upward with wrap-around.
  - On XFER, ptr ← (src+1) mod DRVRS.
  - Reset value of ptr: 0.
- Fixed priority: the lowest set index wins; ptr is unused.
- Stall counter:
  - Cleared on entry to CHECK.
  - Increments every CHECK cycle while blocked.
  - Saturates at TIMEOUT.
- Simultaneous events: pndng or full changes during CHECK/XFER do not affect the latched src, pkt or mask. Exception: full is re-evaluated every CHECK cycle.
- Reset mid-operation: any in-flight packet is abandoned without a pop, so it remains in its source FIFO.

## Timing
- Outputs are decoded from registered state only; there is no combinational path from inputs to outputs.
- Reset values: pop = 0, push = 0, D_push = 0, err_drop = 0, busy = 0. State = IDLE, ptr = 0, counter = 0.
- Minimum latency: pndng seen in cycle N (IDLE) → CHECK in N+1 → pop/push high in N+2. Throughput is 1 packet per 3 cycles.
- pop and push are each high for exactly one cycle, in the same cycle.
- The IDLE cycle after XFER samples post-pop pndng.
- With full held high, pop/err_drop appear TIMEOUT+1 cycles after CHECK entry.
- D_push holds pkt from CHECK entry until the next latch. It is 0 only after reset.

## Configuration
- BUS_BCAST_EN defined:
  - dest ID 0xFF is broadcast; mask = all ports except src.
  - The broadcast waits until every masked destination is not full.
  - The timeout drops the packet for all destinations; there is no partial delivery.
- BUS_BCAST_EN undefined:
  - 0xFF is treated like any other out-of-range ID: mask = 0, err_drop pulse, packet popped.
  - The broadcast mask logic is not synthesised.

## Test plan
- Unicast, DRVRS = 8: pndng[2] = 1 with D_pop[2] = 16'h05AB → cycle N+2: pop = 8'h04, push = 8'h20, D_push = 16'h05AB, err_drop = 0.
- Round-robin fairness: pndng = 8'hFF held, ARB_MODE = 0, ptr = 0 → grants in order 0,1,…,7,0. With ARB_MODE = 1 → grant is always 0.
- Backpressure and timeout, TIMEOUT = 4: unicast to 3 with full[3] held high → no pop for 4 stall cycles, then pop[src] = 1, push = 0, err_drop = 1. Releasing full[3] after 2 cycles instead → normal delivery, err_drop = 0.
- Invalid destination: dest = 8'h10 → pop[src] = 1, push = 0, err_drop = 1 for one cycle.
- Broadcast: with BUS_BCAST_EN, src = 1 and dest = 8'hFF → push = 8'hFD, D_push = pkt. Without the macro → push = 0, err_drop = 1.
- Async reset: assert reset in CHECK → pop/push never pulse, outputs read 0 immediately, and the source FIFO keeps its word.
